axi4l_apb_bridge_mslv: RTL and testbench

Parametrised AXI4-Lite slave to multi-slave APB master bridge; next generation of the single-channel bridge. Independent AW/W capture, read/write fairness arbitration, mask/base address decode across NUM_SLAVES APB targets, DECERR for unmapped addresses, full AXI B/R backpressure. Sits between the AXI interconnect and the peripheral APB segment.

---
 rtl/axi_apb_pkg.sv | 21 ++
 rtl/apb_addr_decoder.sv | 34 +++
 rtl/axi4l_apb_bridge_mslv.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_axi4l_apb_bridge_mslv.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_apb_pkg.sv
// Shared definitions for the AXI4-Lite to multi-slave APB bridge.
//   - AXI response codes
//   - bridge FSM state type
//   - select vector driven when an address decodes to no slave
package axi_apb_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } state_e;

   // Wide enough for the largest supported slave count (16); sliced by users.
   localparam logic [15:0] DEC_MISS_SEL = 16'h0000;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder for the APB segment.
// Slave i hits when (addr & mask_i) == base_i; the lowest hitting index wins.
// Ports:
//   addr_i  address to decode
//   sel_o   one-hot slave select (all zero on a miss)
//   hit_o   at least one slave matched
module apb_addr_decoder
   import axi_apb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {NUM_SLAVES{32'h0}},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {NUM_SLAVES{32'hFFFF_F000}}
) (
   input  logic [ADDR_W-1:0]     addr_i,
   output logic [NUM_SLAVES-1:0] sel_o,
   output logic                  hit_o
);

   always_comb begin
      logic found;
      found = 1'b0;
      sel_o = DEC_MISS_SEL[NUM_SLAVES-1:0];
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!found &&
             ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
            sel_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      hit_o = found;
   end

endmodule

// File: rtl/axi4l_apb_bridge_mslv.sv
// AXI4-Lite slave to multi-slave APB master bridge.
// AW and W are captured independently into one-deep holders; reads and writes are
// granted from IDLE with a toggling priority so neither starves. Addresses are decoded
// by base/mask across NUM_SLAVES APB targets; unmapped addresses answer DECERR without
// an APB cycle. All outputs are registered except awready/wready/arready.
// Optional feature macro: APB_TIMEOUT_EN -- aborts an ACCESS phase that lasts
// TIMEOUT_CYCLES cycles without pready and answers SLVERR.
// Ports:
//   s_axi_clk, s_axi_areset         clock, asynchronous active-high reset
//   s_axi_aw*, s_axi_w*, s_axi_b*   AXI4-Lite write address / data / response
//   s_axi_ar*, s_axi_r*             AXI4-Lite read address / data
//   m_apb_*                         APB master; psel one-hot, prdata flattened (slave 0 LSBs)
module axi4l_apb_bridge_mslv
   import axi_apb_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned NUM_SLAVES     = 4,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {NUM_SLAVES{32'h0}},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {NUM_SLAVES{32'hFFFF_F000}},
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                         s_axi_clk,
   input  logic                         s_axi_areset,
   // write address
   input  logic [ADDR_W-1:0]            s_axi_awaddr,
   input  logic [2:0]                   s_axi_awprot,
   input  logic                         s_axi_awvalid,
   output logic                         s_axi_awready,
   // write data
   input  logic [DATA_W-1:0]            s_axi_wdata,
   input  logic [DATA_W/8-1:0]          s_axi_wstrb,
   input  logic                         s_axi_wvalid,
   output logic                         s_axi_wready,
   // write response
   output logic [1:0]                   s_axi_bresp,
   output logic                         s_axi_bvalid,
   input  logic                         s_axi_bready,
   // read address
   input  logic [ADDR_W-1:0]            s_axi_araddr,
   input  logic [2:0]                   s_axi_arprot,
   input  logic                         s_axi_arvalid,
   output logic                         s_axi_arready,
   // read data
   output logic [DATA_W-1:0]            s_axi_rdata,
   output logic [1:0]                   s_axi_rresp,
   output logic                         s_axi_rvalid,
   input  logic                         s_axi_rready,
   // APB master
   output logic [ADDR_W-1:0]            m_apb_paddr,
   output logic [2:0]                   m_apb_pprot,
   output logic [NUM_SLAVES-1:0]        m_apb_psel,
   output logic                         m_apb_penable,
   output logic                         m_apb_pwrite,
   output logic [DATA_W-1:0]            m_apb_pwdata,
   output logic [DATA_W/8-1:0]          m_apb_pstrb,
   input  logic [NUM_SLAVES-1:0]        m_apb_pready,
   input  logic [NUM_SLAVES*DATA_W-1:0] m_apb_prdata,
   input  logic [NUM_SLAVES-1:0]        m_apb_pslverr
);

   localparam int unsigned StrbW = DATA_W / 8;

   state_e                  state_q, state_d;

   // AW / W holders
   logic                    aw_full_q, aw_full_d;
   logic [ADDR_W-1:0]       aw_addr_q, aw_addr_d;
   logic [2:0]              aw_prot_q, aw_prot_d;
   logic                    w_full_q, w_full_d;
   logic [DATA_W-1:0]       w_data_q, w_data_d;
   logic [StrbW-1:0]        w_strb_q, w_strb_d;

   logic                    prio_read_q, prio_read_d;
   logic                    is_wr_q, is_wr_d;

   // Registered outputs
   logic [ADDR_W-1:0]       paddr_q, paddr_d;
   logic [2:0]              pprot_q, pprot_d;
   logic [NUM_SLAVES-1:0]   psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATA_W-1:0]       pwdata_q, pwdata_d;
   logic [StrbW-1:0]        pstrb_q, pstrb_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic                    rvalid_q, rvalid_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;

   logic                    aw_ready, w_ready, ar_ready;
   logic                    wr_rdy, is_idle, rd_grant, wr_grant;
   logic [ADDR_W-1:0]       dec_addr;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_hit;
   logic                    sel_ready, sel_err;
   logic [DATA_W-1:0]       sel_rdata;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TmoRaw  = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned TmoW    = (TmoRaw < 8) ? 8 : ((TmoRaw > 16) ? 16 : TmoRaw);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
   logic [TmoW-1:0]         tmo_q, tmo_d;
`endif

   // Ready flags are held low while reset is asserted so every output reads 0 in reset.
   assign wr_rdy   = aw_full_q & w_full_q;
   assign is_idle  = (state_q == StIdle);
   assign aw_ready = ~s_axi_areset & ~aw_full_q;
   assign w_ready  = ~s_axi_areset & ~w_full_q;
   assign ar_ready = ~s_axi_areset & is_idle & (~wr_rdy | prio_read_q);
   assign rd_grant = s_axi_arvalid & ar_ready;
   assign wr_grant = ~s_axi_areset & is_idle & wr_rdy & (~s_axi_arvalid | ~prio_read_q);
   assign dec_addr = rd_grant ? s_axi_araddr : aw_addr_q;

   apb_addr_decoder #(
      .ADDR_W     (ADDR_W),
      .NUM_SLAVES (NUM_SLAVES),
      .SLV_BASE   (SLV_BASE),
      .SLV_MASK   (SLV_MASK)
   ) u_dec (
      .addr_i (dec_addr),
      .sel_o  (dec_sel),
      .hit_o  (dec_hit)
   );

   // Only the selected slave's ready/error/data are seen; psel_q is one-hot or zero.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (psel_q[i]) begin
            sel_ready = sel_ready | m_apb_pready[i];
            sel_err   = sel_err | m_apb_pslverr[i];
            sel_rdata = sel_rdata | m_apb_prdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      aw_full_d   = aw_full_q;
      aw_addr_d   = aw_addr_q;
      aw_prot_d   = aw_prot_q;
      w_full_d    = w_full_q;
      w_data_d    = w_data_q;
      w_strb_d    = w_strb_q;
      prio_read_d = prio_read_q;
      is_wr_d     = is_wr_q;
      paddr_d     = paddr_q;
      pprot_d     = pprot_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;
      rvalid_d    = rvalid_q;
      rresp_d     = rresp_q;
      rdata_d     = rdata_q;
`ifdef APB_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif

      // Holders capture in any state; a holder is never full and loading at once.
      if (aw_full_q) begin
         if (wr_grant) aw_full_d = 1'b0;
      end else if (s_axi_awvalid && aw_ready) begin
         aw_full_d = 1'b1;
         aw_addr_d = s_axi_awaddr;
         aw_prot_d = s_axi_awprot;
      end
      if (w_full_q) begin
         if (wr_grant) w_full_d = 1'b0;
      end else if (s_axi_wvalid && w_ready) begin
         w_full_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end

      unique case (state_q)
         StIdle: begin
            if (rd_grant || wr_grant) begin
               prio_read_d = ~prio_read_q;
               is_wr_d     = wr_grant;
               if (dec_hit) begin
                  state_d   = StSetup;
                  psel_d    = dec_sel;
                  penable_d = 1'b0;
                  paddr_d   = dec_addr;
                  pprot_d   = wr_grant ? aw_prot_q : s_axi_arprot;
                  pwrite_d  = wr_grant;
                  pwdata_d  = wr_grant ? w_data_q : '0;
                  pstrb_d   = wr_grant ? w_strb_q : '0;
               end else begin
                  state_d = StResp;
                  if (wr_grant) begin
                     bvalid_d = 1'b1;
                     bresp_d  = RESP_DECERR;
                  end else begin
                     rvalid_d = 1'b1;
                     rresp_d  = RESP_DECERR;
                     rdata_d  = '0;
                  end
               end
            end
         end
         StSetup: begin
            penable_d = 1'b1;
            state_d   = StAccess;
`ifdef APB_TIMEOUT_EN
            tmo_d     = '0;
`endif
         end
         StAccess: begin
            if (sel_ready) begin
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = StResp;
               if (is_wr_q) begin
                  bvalid_d = 1'b1;
                  bresp_d  = sel_err ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = sel_err ? RESP_SLVERR : RESP_OKAY;
                  rdata_d  = sel_rdata;
               end
            end
`ifdef APB_TIMEOUT_EN
            else if (tmo_q == TmoLast) begin
               psel_d    = '0;
               penable_d = 1'b0;
               state_d   = StResp;
               if (is_wr_q) begin
                  bvalid_d = 1'b1;
                  bresp_d  = RESP_SLVERR;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = RESP_SLVERR;
                  rdata_d  = '0;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         StResp: begin
            if ((bvalid_q && s_axi_bready) || (rvalid_q && s_axi_rready)) begin
               bvalid_d = 1'b0;
               rvalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge s_axi_clk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         state_q     <= StIdle;
         aw_full_q   <= 1'b0;
         aw_addr_q   <= '0;
         aw_prot_q   <= '0;
         w_full_q    <= 1'b0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         prio_read_q <= 1'b1;
         is_wr_q     <= 1'b0;
         paddr_q     <= '0;
         pprot_q     <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         bvalid_q    <= 1'b0;
         bresp_q     <= '0;
         rvalid_q    <= 1'b0;
         rresp_q     <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         aw_full_q   <= aw_full_d;
         aw_addr_q   <= aw_addr_d;
         aw_prot_q   <= aw_prot_d;
         w_full_q    <= w_full_d;
         w_data_q    <= w_data_d;
         w_strb_q    <= w_strb_d;
         prio_read_q <= prio_read_d;
         is_wr_q     <= is_wr_d;
         paddr_q     <= paddr_d;
         pprot_q     <= pprot_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         rvalid_q    <= rvalid_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   always_ff @(posedge s_axi_clk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign s_axi_awready = aw_ready;
   assign s_axi_wready  = w_ready;
   assign s_axi_arready = ar_ready;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign m_apb_paddr   = paddr_q;
   assign m_apb_pprot   = pprot_q;
   assign m_apb_psel    = psel_q;
   assign m_apb_penable = penable_q;
   assign m_apb_pwrite  = pwrite_q;
   assign m_apb_pwdata  = pwdata_q;
   assign m_apb_pstrb   = pstrb_q;

endmodule

// File: tb/tb_axi4l_apb_bridge_mslv.sv
module tb_axi4l_apb_bridge_mslv;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NS = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [AW-1:0]     awaddr = '0;
   logic [2:0]        awprot = '0;
   logic              awvalid = 1'b0;
   logic              awready;
   logic [DW-1:0]     wdata = '0;
   logic [DW/8-1:0]   wstrb = '0;
   logic              wvalid = 1'b0;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready = 1'b1;
   logic [AW-1:0]     araddr = '0;
   logic [2:0]        arprot = '0;
   logic              arvalid = 1'b0;
   logic              arready;
   logic [DW-1:0]     rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready = 1'b1;
   logic [AW-1:0]     paddr;
   logic [2:0]        pprot;
   logic [NS-1:0]     psel;
   logic              penable;
   logic              pwrite;
   logic [DW-1:0]     pwdata;
   logic [DW/8-1:0]   pstrb;
   logic [NS-1:0]     pready = 4'b1111;
   logic [NS*DW-1:0]  prdata = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_00A0};
   logic [NS-1:0]     pslverr = 4'b0000;

   int checks = 0;
   int errors = 0;
   bit seen;

   always #5 clk = ~clk;

   axi4l_apb_bridge_mslv #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .NUM_SLAVES (NS),
      .SLV_BASE   ({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
      .SLV_MASK   ({4{32'hFFFF_F000}})
   ) dut (
      .s_axi_clk     (clk),
      .s_axi_areset  (rst),
      .s_axi_awaddr  (awaddr),
      .s_axi_awprot  (awprot),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arprot  (arprot),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .m_apb_paddr   (paddr),
      .m_apb_pprot   (pprot),
      .m_apb_psel    (psel),
      .m_apb_penable (penable),
      .m_apb_pwrite  (pwrite),
      .m_apb_pwdata  (pwdata),
      .m_apb_pstrb   (pstrb),
      .m_apb_pready  (pready),
      .m_apb_prdata  (prdata),
      .m_apb_pslverr (pslverr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until a SETUP phase (psel set, penable low) is visible, bounded.
   task automatic wait_setup(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (psel != '0 && !penable) found = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "simulation timeout");
   end

   initial begin
      // ---------------- reset ----------------
      #1 rst = 1'b1;
      step();
      chk("rst_psel", psel, 4'b0000);
      chk("rst_penable", penable, 1'b0);
      chk("rst_bvalid", bvalid, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_awready", awready, 1'b0);
      chk("rst_arready", arready, 1'b0);
      step();
      rst = 1'b0;
      #1;
      chk("post_rst_awready", awready, 1'b1);
      chk("post_rst_wready", wready, 1'b1);
      chk("post_rst_arready", arready, 1'b1);

      // ---------------- read 0x2004, zero-wait slave 2 ----------------
      // Unselected slaves flag errors; they must be ignored.
      pslverr = 4'b1011;
      araddr  = 32'h0000_2004;
      arprot  = 3'b010;
      arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      chk("rd_c1_psel", psel, 4'b0100);
      chk("rd_c1_penable", penable, 1'b0);
      chk("rd_c1_pwrite", pwrite, 1'b0);
      chk("rd_c1_paddr", paddr, 32'h0000_2004);
      chk("rd_c1_pprot", pprot, 3'b010);
      chk("rd_c1_pstrb", pstrb, 4'b0000);
      chk("rd_c1_pwdata", pwdata, 32'h0);
      chk("rd_c1_rvalid", rvalid, 1'b0);
      step();
      chk("rd_c2_penable", penable, 1'b1);
      chk("rd_c2_psel", psel, 4'b0100);
      step();
      chk("rd_c3_rvalid", rvalid, 1'b1);
      chk("rd_c3_rdata", rdata, 32'hDEAD_BEEF);
      chk("rd_c3_rresp", rresp, 2'b00);
      chk("rd_c3_psel", psel, 4'b0000);
      chk("rd_c3_penable", penable, 1'b0);
      step();
      chk("rd_done_rvalid", rvalid, 1'b0);
      pslverr = 4'b0000;

      // ---------------- W three cycles ahead of AW, slave 1 ----------------
      wdata  = 32'h1234_5678;
      wstrb  = 4'b0011;
      wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      chk("wr_w_held_wready", wready, 1'b0);
      chk("wr_w_only_psel", psel, 4'b0000);
      step();
      step();
      awaddr  = 32'h0000_1008;
      awprot  = 3'b001;
      awvalid = 1'b1;
      #1;
      chk("wr_awready", awready, 1'b1);
      step();
      awvalid = 1'b0;
      chk("wr_aw_held_awready", awready, 1'b0);
      chk("wr_grant_cycle_psel", psel, 4'b0000);
      step();
      chk("wr_setup_psel", psel, 4'b0010);
      chk("wr_setup_pwrite", pwrite, 1'b1);
      chk("wr_setup_paddr", paddr, 32'h0000_1008);
      chk("wr_setup_pwdata", pwdata, 32'h1234_5678);
      chk("wr_setup_pstrb", pstrb, 4'b0011);
      chk("wr_setup_pprot", pprot, 3'b001);
      chk("wr_holders_free", awready & wready, 1'b1);
      step();
      chk("wr_access_penable", penable, 1'b1);
      step();
      chk("wr_bvalid", bvalid, 1'b1);
      chk("wr_bresp", bresp, 2'b00);
      step();
      chk("wr_done_bvalid", bvalid, 1'b0);

      // ---------------- fairness: read and write pending together ----------------
      // Priority is with reads again after one read and one write.
      awaddr  = 32'h0000_3000;
      awprot  = 3'b000;
      wdata   = 32'hA5A5_0001;
      wstrb   = 4'b1111;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      araddr  = 32'h0000_3004;
      arprot  = 3'b000;
      arvalid = 1'b1;
      wait_setup(seen);
      chk("fair_g1_seen", seen, 1'b1);
      chk("fair_g1_pwrite", pwrite, 1'b0);
      chk("fair_g1_paddr", paddr, 32'h0000_3004);
      wait_setup(seen);
      chk("fair_g2_seen", seen, 1'b1);
      chk("fair_g2_pwrite", pwrite, 1'b1);
      chk("fair_g2_paddr", paddr, 32'h0000_3000);
      chk("fair_g2_pwdata", pwdata, 32'hA5A5_0001);
      awaddr  = 32'h0000_3008;
      wdata   = 32'hA5A5_0002;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wait_setup(seen);
      chk("fair_g3_seen", seen, 1'b1);
      chk("fair_g3_pwrite", pwrite, 1'b0);
      wait_setup(seen);
      arvalid = 1'b0;
      chk("fair_g4_seen", seen, 1'b1);
      chk("fair_g4_pwrite", pwrite, 1'b1);
      chk("fair_g4_paddr", paddr, 32'h0000_3008);
      chk("fair_g4_pwdata", pwdata, 32'hA5A5_0002);
      step();
      step();
      step();
      step();
      chk("fair_drain_arready", arready, 1'b1);
      chk("fair_drain_psel", psel, 4'b0000);

      // ---------------- unmapped read 0x9000 ----------------
      araddr  = 32'h0000_9000;
      arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      chk("miss_psel", psel, 4'b0000);
      chk("miss_rvalid", rvalid, 1'b1);
      chk("miss_rresp", rresp, 2'b11);
      chk("miss_rdata", rdata, 32'h0);
      step();
      chk("miss_done_rvalid", rvalid, 1'b0);

      // ---------------- slave 0 wait states, pslverr, B backpressure ----------------
      pready  = 4'b1110;
      bready  = 1'b0;
      awaddr  = 32'h0000_0010;
      wdata   = 32'hCAFE_F00D;
      wstrb   = 4'b1111;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      step();
      chk("err_setup_psel", psel, 4'b0001);
      chk("err_setup_penable", penable, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("err_wait%0d_penable", k), penable, 1'b1);
         chk($sformatf("err_wait%0d_bvalid", k), bvalid, 1'b0);
      end
      step();
      chk("err_wait6_penable", penable, 1'b1);
      pready  = 4'b1111;
      pslverr = 4'b0001;
      step();
      pslverr = 4'b0000;
      chk("err_bvalid", bvalid, 1'b1);
      chk("err_bresp", bresp, 2'b10);
      chk("err_psel_off", psel, 4'b0000);
      chk("err_penable_off", penable, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("err_hold%0d_bvalid", k), bvalid, 1'b1);
         chk($sformatf("err_hold%0d_bresp", k), bresp, 2'b10);
      end
      bready = 1'b1;
      step();
      chk("err_done_bvalid", bvalid, 1'b0);

      // ---------------- reset during ACCESS ----------------
      pready  = 4'b0000;
      araddr  = 32'h0000_1000;
      arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      step();
      chk("rst_mid_penable_before", penable, 1'b1);
      chk("rst_mid_psel_before", psel, 4'b0010);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_psel", psel, 4'b0000);
      chk("rst_mid_penable", penable, 1'b0);
      chk("rst_mid_paddr", paddr, 32'h0);
      chk("rst_mid_rvalid", rvalid, 1'b0);
      @(negedge clk);
      rst    = 1'b0;
      pready = 4'b1111;
      step();
      step();
      step();
      chk("rst_mid_no_resp", rvalid, 1'b0);
      chk("rst_mid_idle_psel", psel, 4'b0000);
      chk("rst_mid_idle_arready", arready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
